// File: rtl/riscv_pkg.sv
// Shared encodings for the MEM/WB stage: write-back load types, store byte masks,
// access-unit FSM states and the register bundles the access unit carries.
package riscv_pkg;

  typedef enum logic [2:0] {
    RW_NONE = 3'd0,
    RW_LB   = 3'd1,
    RW_LH   = 3'd2,
    RW_LW   = 3'd3,
    RW_LBU  = 3'd4,
    RW_LHU  = 3'd5,
    RW_ALU  = 3'd6
  } regwrite_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mau_state_e;

  typedef struct packed {
    logic        req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_cmd_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        regwrite;
    logic        valid;
  } wb_t;

  // Everything needed to finish an access once the memory answers.
  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] ld_type;
    logic [1:0] lo;
    logic       is_load;
  } pend_op_t;

  function automatic logic is_misaligned(input logic       is_load,
                                         input logic [2:0] rw,
                                         input logic [3:0] mask,
                                         input logic [1:0] lo);
    logic half_acc;
    logic word_acc;
    half_acc = is_load ? (rw == RW_LH || rw == RW_LHU) : (mask == MASK_H);
    word_acc = is_load ? (rw == RW_LW) : (mask == MASK_W);
    return (half_acc && lo[0]) || (word_acc && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory port of the MEM stage: registered request out, ready/rdata back.
interface mem_access_unit_if;
  logic        dmem_req;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a loaded word and sign- or zero-extends it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  ld_type,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{addr, 3'b000} +: 8];
    half_v = word[{addr[1], 4'b0000} +: 16];
    // NOTE: the default arm assigns result on every path, so no latch is inferred.
    case (ld_type)
      RW_LB:   result = {{24{byte_v[7]}}, byte_v};
      RW_LH:   result = {{16{half_v[15]}}, half_v};
      RW_LBU:  result = {24'h0, byte_v};
      RW_LHU:  result = {16'h0, half_v};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage access unit: passes ALU results to WB, runs one outstanding data-memory
// access at a time through an IDLE/BUSY FSM, and stalls upstream while it waits.
module mem_access_unit
  import riscv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              AluOutM,
  input  logic [31:0]              StoreDataM,
  input  logic [4:0]               RdM,
  input  logic [31:0]              PCM,
  input  logic [2:0]               RegWriteM,
  input  logic                     MemToRegM,
  input  logic [3:0]               MemWriteM,
  input  logic                     LoadNpcM,
  input  logic                     flush_w,
  mem_access_unit_if.master        dmem,
  output logic [31:0]              ResultW,
  output logic [4:0]               RdW,
  output logic                     RegWriteW,
  output logic                     ValidW,
  output logic                     stall_mem,
  output logic                     misalign_err
);

  mau_state_e state_q, state_d;
  dmem_cmd_t  cmd_q, cmd_d;
  pend_op_t   op_q, op_d;
  wb_t        wb_q, wb_d;
  logic       misalign_q, misalign_d;

  logic        is_mem;
  logic        misaligned;
  logic [31:0] load_word;

  assign is_mem     = MemToRegM || (MemWriteM != 4'b0000);
  assign misaligned = is_misaligned(MemToRegM, RegWriteM, MemWriteM, AluOutM[1:0]);

  load_extend u_load_extend (
    .word    (dmem.dmem_rdata),
    .addr    (op_q.lo),
    .ld_type (op_q.ld_type),
    .result  (load_word)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    op_d       = op_q;
    wb_d       = '0;
    misalign_d = 1'b0;
    stall_mem  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flush_w) begin
          // Dropped op: bubble, no request, and no stall so it does not linger.
        end else if (!is_mem) begin
          wb_d.result   = LoadNpcM ? (PCM + 32'd4) : AluOutM;
          wb_d.rd       = RdM;
          wb_d.regwrite = (RegWriteM != RW_NONE) && (RdM != 5'd0);
          wb_d.valid    = 1'b1;
        end else if (misaligned) begin
          misalign_d = 1'b1;
        end else begin
          stall_mem     = 1'b1;
          state_d       = S_BUSY;
          cmd_d.req     = 1'b1;
          cmd_d.we      = MemWriteM << AluOutM[1:0];
          cmd_d.addr    = {AluOutM[31:2], 2'b00};
          cmd_d.wdata   = StoreDataM << {AluOutM[1:0], 3'b000};
          op_d.rd       = RdM;
          op_d.ld_type  = RegWriteM;
          op_d.lo       = AluOutM[1:0];
          op_d.is_load  = MemToRegM;
        end
      end
      S_BUSY: begin
        if (!dmem.dmem_ready) begin
          stall_mem = 1'b1;
        end else begin
          state_d    = S_IDLE;
          cmd_d      = '0;
          wb_d.valid = 1'b1;
          if (op_q.is_load) begin
            wb_d.result   = load_word;
            wb_d.rd       = op_q.rd;
            wb_d.regwrite = (op_q.rd != 5'd0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs read 0 during reset even though this path is combinational.
    if (!rst_n) stall_mem = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      op_q       <= '0;
      wb_q       <= '0;
      misalign_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      op_q       <= op_d;
      wb_q       <= wb_d;
      misalign_q <= misalign_d;
    end
  end

  assign dmem.dmem_req   = cmd_q.req;
  assign dmem.dmem_we    = cmd_q.we;
  assign dmem.dmem_addr  = cmd_q.addr;
  assign dmem.dmem_wdata = cmd_q.wdata;

  assign ResultW      = wb_q.result;
  assign RdW          = wb_q.rd;
  assign RegWriteW    = wb_q.regwrite;
  assign ValidW       = wb_q.valid;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases plus random ops
// checked against a byte-address/size reference model.
module tb_mem_access_unit;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] AluOutM, StoreDataM, PCM;
  logic [4:0]  RdM;
  logic [2:0]  RegWriteM;
  logic        MemToRegM;
  logic [3:0]  MemWriteM;
  logic        LoadNpcM;
  logic        flush_w;
  logic [31:0] ResultW;
  logic [4:0]  RdW;
  logic        RegWriteW, ValidW, stall_mem, misalign_err;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_access_unit_if dmem_bus ();

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .AluOutM      (AluOutM),
    .StoreDataM   (StoreDataM),
    .RdM          (RdM),
    .PCM          (PCM),
    .RegWriteM    (RegWriteM),
    .MemToRegM    (MemToRegM),
    .MemWriteM    (MemWriteM),
    .LoadNpcM     (LoadNpcM),
    .flush_w      (flush_w),
    .dmem         (dmem_bus),
    .ResultW      (ResultW),
    .RdW          (RdW),
    .RegWriteW    (RegWriteW),
    .ValidW       (ValidW),
    .stall_mem    (stall_mem),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes, from the load type or the store mask.
  function automatic int acc_size(input logic mtr, input logic [2:0] rw, input logic [3:0] mw);
    if (mtr) begin
      case (rw)
        3'd1, 3'd4: return 1;
        3'd2, 3'd5: return 2;
        default:    return 4;
      endcase
    end
    case (mw)
      4'b0001: return 1;
      4'b0011: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_ref(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [2:0] rw);
    logic [31:0] raw, v;
    raw = rdata >> (8 * (addr % 4));
    case (rw)
      3'd1: begin v = raw % 256;   return (v >= 128)   ? v - 32'd256   : v; end
      3'd2: begin v = raw % 65536; return (v >= 32768) ? v - 32'd65536 : v; end
      3'd4: return raw % 256;
      3'd5: return raw % 65536;
      default: return rdata;
    endcase
  endfunction

  task automatic idle_step(input string tag);
    MemToRegM = 1'b0; MemWriteM = 4'b0; RegWriteM = 3'd0; flush_w = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".idle_valid"}, ValidW, 0);
    chk({tag, ".idle_misalign"}, misalign_err, 0);
    flush_w = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic mtr, input logic [2:0] rw,
                        input logic [3:0] mw, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic npc, input logic [31:0] pc,
                        input int waits, input logic [31:0] rdata, input bit flush_in_busy);
    int lo;
    int stalls;
    logic [3:0] exp_we;
    lo = int'(addr % 4);
    AluOutM = addr; StoreDataM = sdata; RdM = rd; PCM = pc; RegWriteM = rw;
    MemToRegM = mtr; MemWriteM = mw; LoadNpcM = npc; flush_w = 1'b0;
    dmem_bus.dmem_ready = 1'b0;
    dmem_bus.dmem_rdata = $urandom;
    #1;
    if (!mtr && mw == 4'b0) begin
      chk({tag, ".stall"}, stall_mem, 0);
      @(posedge clk); #1;
      chk({tag, ".result"}, ResultW, npc ? pc + 32'd4 : addr);
      chk({tag, ".rd"}, RdW, rd);
      chk({tag, ".regwrite"}, RegWriteW, (rw != 3'd0 && rd != 5'd0));
      chk({tag, ".valid"}, ValidW, 1);
      chk({tag, ".misalign"}, misalign_err, 0);
    end else if (addr % acc_size(mtr, rw, mw) != 0) begin
      chk({tag, ".mis_stall"}, stall_mem, 0);
      @(posedge clk); #1;
      chk({tag, ".mis_err"}, misalign_err, 1);
      chk({tag, ".mis_req"}, dmem_bus.dmem_req, 0);
      chk({tag, ".mis_valid"}, ValidW, 0);
      chk({tag, ".mis_regwrite"}, RegWriteW, 0);
      idle_step(tag);
    end else begin
      stalls = 0;
      if (stall_mem) stalls++;
      @(posedge clk); #1;
      exp_we = mw << lo;
      chk({tag, ".req"}, dmem_bus.dmem_req, 1);
      chk({tag, ".addr"}, dmem_bus.dmem_addr, addr - addr % 4);
      chk({tag, ".we"}, dmem_bus.dmem_we, exp_we);
      chk({tag, ".wdata"}, dmem_bus.dmem_wdata, sdata << (8 * lo));
      chk({tag, ".bubble"}, ValidW, 0);
      chk({tag, ".misalign0"}, misalign_err, 0);
      for (int w = 0; w < waits; w++) begin
        if (flush_in_busy) flush_w = 1'b1;
        #1;
        if (stall_mem) stalls++;
        @(posedge clk); #1;
        chk({tag, ".wait_valid"}, ValidW, 0);
        chk({tag, ".wait_req"}, dmem_bus.dmem_req, 1);
      end
      dmem_bus.dmem_ready = 1'b1;
      dmem_bus.dmem_rdata = rdata;
      #1;
      chk({tag, ".ready_stall"}, stall_mem, 0);
      chk({tag, ".stall_cycles"}, stalls, waits + 1);
      @(posedge clk); #1;
      dmem_bus.dmem_ready = 1'b0;
      flush_w = 1'b0;
      chk({tag, ".done_req"}, dmem_bus.dmem_req, 0);
      chk({tag, ".done_valid"}, ValidW, 1);
      chk({tag, ".done_regwrite"}, RegWriteW, (mtr && rd != 5'd0));
      if (mtr) begin
        chk({tag, ".load_result"}, ResultW, load_ref(rdata, addr, rw));
        chk({tag, ".load_rd"}, RdW, rd);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [3:0] masks [3];
    logic       r_mtr, r_npc;
    logic [2:0] r_rw;
    logic [3:0] r_mw;
    logic [31:0] r_addr;
    int          kind;
    masks[0] = 4'b0001; masks[1] = 4'b0011; masks[2] = 4'b1111;

    // Reset with a memory op already presented: everything must read 0.
    rst_n = 1'b0;
    AluOutM = 32'h400; StoreDataM = 32'h0; RdM = 5'd3; PCM = 32'h0; RegWriteM = 3'd3;
    MemToRegM = 1'b1; MemWriteM = 4'b0; LoadNpcM = 1'b0; flush_w = 1'b0;
    dmem_bus.dmem_ready = 1'b0; dmem_bus.dmem_rdata = 32'h0;
    @(posedge clk); #1;
    chk("rst.stall", stall_mem, 0);
    chk("rst.req", dmem_bus.dmem_req, 0);
    chk("rst.we", dmem_bus.dmem_we, 0);
    chk("rst.addr", dmem_bus.dmem_addr, 0);
    chk("rst.wdata", dmem_bus.dmem_wdata, 0);
    chk("rst.result", ResultW, 0);
    chk("rst.rd", RdW, 0);
    chk("rst.regwrite", RegWriteW, 0);
    chk("rst.valid", ValidW, 0);
    chk("rst.misalign", misalign_err, 0);
    MemToRegM = 1'b0; RegWriteM = 3'd0;
    rst_n = 1'b1;

    run_op("alu", 0, RW_ALU, 4'b0, 32'h10, 32'h0, 5'd5, 0, 32'h0, 0, 0, 0);
    run_op("npc_wrap", 0, RW_ALU, 4'b0, 32'h1234, 32'h0, 5'd9, 1, 32'hFFFF_FFFC, 0, 0, 0);
    run_op("alu_rd0", 0, RW_ALU, 4'b0, 32'hABCD, 32'h0, 5'd0, 0, 32'h0, 0, 0, 0);
    run_op("lb_wait3", 1, RW_LB, 4'b0, 32'h103, 32'h0, 5'd4, 0, 32'h0, 3, 32'h80FF_FF12, 0);
    run_op("sh_202", 0, RW_NONE, MASK_H, 32'h202, 32'h0000_BEEF, 5'd0, 0, 32'h0, 1, 32'h0, 0);
    run_op("lw_mis", 1, RW_LW, 4'b0, 32'h301, 32'h0, 5'd6, 0, 32'h0, 0, 32'h0, 0);
    run_op("lhu_fast", 1, RW_LHU, 4'b0, 32'h502, 32'h0, 5'd8, 0, 32'h0, 0, 32'h8765_4321, 0);
    run_op("lh_flushbusy", 1, RW_LH, 4'b0, 32'h600, 32'h0, 5'd0, 0, 32'h0, 2, 32'h1234_8001, 1);

    // Flush in IDLE: memory op issues nothing, ALU op becomes a bubble.
    AluOutM = 32'h700; MemToRegM = 1'b1; RegWriteM = 3'd3; RdM = 5'd2; flush_w = 1'b1;
    @(posedge clk); #1;
    chk("flush_mem.req", dmem_bus.dmem_req, 0);
    chk("flush_mem.valid", ValidW, 0);
    MemToRegM = 1'b0; RegWriteM = 3'd6;
    @(posedge clk); #1;
    chk("flush_alu.valid", ValidW, 0);
    chk("flush_alu.regwrite", RegWriteW, 0);
    flush_w = 1'b0;

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      r_addr = $urandom;
      if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
      r_npc = 1'b0; r_mtr = 1'b0; r_mw = 4'b0;
      if (kind == 0) begin
        r_rw  = ($urandom_range(0, 1) == 1) ? 3'd6 : 3'd0;
        r_npc = 1'($urandom_range(0, 1));
      end else if (kind == 1) begin
        r_rw  = 3'($urandom_range(1, 5));
        r_mtr = 1'b1;
      end else begin
        r_rw = 3'd0;
        r_mw = masks[$urandom_range(0, 2)];
      end
      run_op("rand", r_mtr, r_rw, r_mw, r_addr, $urandom, 5'($urandom), r_npc, $urandom,
             $urandom_range(0, 3), $urandom, 0);
    end

    // Reset in the middle of BUSY, then a late ready must not write back.
    AluOutM = 32'h800; MemToRegM = 1'b1; RegWriteM = 3'd3; RdM = 5'd7; MemWriteM = 4'b0;
    LoadNpcM = 1'b0; flush_w = 1'b0; dmem_bus.dmem_ready = 1'b0;
    @(posedge clk); #1;
    chk("midrst.busy_req", dmem_bus.dmem_req, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst.req", dmem_bus.dmem_req, 0);
    chk("midrst.stall", stall_mem, 0);
    chk("midrst.addr", dmem_bus.dmem_addr, 0);
    dmem_bus.dmem_ready = 1'b1; dmem_bus.dmem_rdata = 32'hDEAD_BEEF;
    MemToRegM = 1'b0; RegWriteM = 3'd0; flush_w = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst.late_regwrite", RegWriteW, 0);
    chk("midrst.late_valid", ValidW, 0);
    chk("midrst.late_result", ResultW, 0);
    chk("midrst.late_req", dmem_bus.dmem_req, 0);
    dmem_bus.dmem_ready = 1'b0; flush_w = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
